uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_if.sv | 25 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 132 +++++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Purpose: shared UART definitions (receiver FSM states, frame defaults, line levels).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_pkg;

    // Frame defaults: 8N1, 16x oversampling.
    localparam int DATA_BITS_DEF  = 8;
    localparam int OVERSAMPLE_DEF = 16;

    // Line levels for 8N1 framing. The idle line and the stop bit are both mark (high).
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Purpose: receiver bus bundle: tick/rx into the receiver, decoded byte and status out.
// Latency: n/a (wires only).
// Backpressure: none; rx_valid/frame_err are single-cycle pulses with no ready.
// Ports: master drives tick, rx and observes rx_data, rx_valid, frame_err, busy;
//        slave (the receiver) is the mirror image.
interface uart_rx_if import uart_pkg::*; #(
    parameter int DATA_BITS = DATA_BITS_DEF
);
    logic                 tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output tick, rx,
        input  rx_data, rx_valid, frame_err, busy
    );

    modport slave (
        input  tick, rx,
        output rx_data, rx_valid, frame_err, busy
    );
endinterface

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchronizer for a single asynchronous bit.
// Latency: 2 clk from d to q.
// Backpressure: none.
// Ports: clk, reset (sync, active-high, loads RESET_VAL into both flops), d (async in), q (synced out).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver, oversampled by an external tick, bits sampled mid-period.
// Latency: rx_valid/frame_err 1 clk after the stop-bit sample tick (+2 clk synchronizer on rx).
// Backpressure: none; rx_data is held until the next good frame, pulses are not retried.
// Ports: clk, reset (sync, active-high), bus (uart_rx_if.slave: tick, rx in;
//        rx_data, rx_valid, frame_err, busy out).
module uart_rx import uart_pkg::*; #(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Start bit is confirmed half a bit in; from then on every full bit period
    // lands on the middle of the next bit.
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state_q,    state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [DATA_BITS-1:0] data_q,     data_d;
    logic                 valid_q,    valid_d;
    logic                 ferr_q,     ferr_d;

    sync_2ff #(.RESET_VAL(IDLE_LEVEL)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    // Everything advances on tick only; the pulses default low so they last one clk.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;

        if (bus.tick) begin
            case (state_q)
                IDLE: begin
                    if (rx_s == START_LEVEL) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        // Line back high at mid start bit: glitch, not a frame.
                        state_d    = (rx_s == START_LEVEL) ? DATA : IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt_q == TICK_END) begin
                        tick_cnt_d         = '0;
                        shift_d[bit_cnt_q] = rx_s;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt_q == TICK_END) begin
                        tick_cnt_d = '0;
                        if (rx_s == STOP_LEVEL) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                BREAK: begin
                    // Wait out a held-low line so it is not decoded as a stream of 0x00 frames.
                    if (rx_s == IDLE_LEVEL) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Purpose: self-checking bench for uart_rx: table of frames plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int vld_seen  = 0;
    int ferr_seen = 0;
    int both_seen = 0;
    int exp_vld   = 0;
    int exp_ferr  = 0;
    logic [7:0] exp_q[$];
    bit   tick_en = 1'b1;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Baud tick: one clk high every 21 clk, changed on the falling edge.
    initial begin
        int div;
        div      = 0;
        bus.tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                if (div == 20) begin
                    bus.tick = 1'b1;
                    div      = 0;
                end else begin
                    bus.tick = 1'b0;
                    div++;
                end
            end else begin
                bus.tick = 1'b0;
            end
        end
    end

    // Scoreboard side: every rx_valid pops one expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rx_valid === 1'b1) begin
                vld_seen++;
                if (exp_q.size() > 0) check("sb_rx_data", bus.rx_data, exp_q.pop_front());
            end
            if (bus.frame_err === 1'b1) ferr_seen++;
            if (bus.rx_valid === 1'b1 && bus.frame_err === 1'b1) both_seen++;
        end
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: got timeout expected run to complete");
        $fatal(1, "watchdog expired");
    end

    // Returns 1 time unit after the posedge of the n-th tick.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (bus.tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        bus.rx = v;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap, input int pause_bit);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == pause_bit) begin
                drive_bit(d[i], 5);
                tick_en = 1'b0;
                repeat (200) @(posedge clk);
                #1 tick_en = 1'b1;
                wait_ticks(11);
            end else begin
                drive_bit(d[i], 16);
            end
        end
        if (stop) begin
            exp_q.push_back(d);
            exp_vld++;
        end else begin
            exp_ferr++;
        end
        // Receiver decides on the 9th tick of the stop bit; pulse must show the next cycle.
        drive_bit(stop, 9);
        @(negedge clk);
        check("stop_rx_valid", bus.rx_valid, stop);
        check("stop_frame_err", bus.frame_err, !stop);
        wait_ticks(7);
        if (gap > 0) drive_bit(1'b1, gap * 16);
    endtask

    initial begin
        bus.rx = 1'b1;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx_data", bus.rx_data, 8'h00);
        check("rst_rx_valid", bus.rx_valid, 1'b0);
        check("rst_frame_err", bus.frame_err, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        reset = 1'b0;
        wait_ticks(4);

        // Frame table: good frames (incl. back-to-back) and one bad stop bit
        vecs[0] = '{8'h55, 1'b1, 2, 8'h55};
        vecs[1] = '{8'hA3, 1'b1, 0, 8'hA3};
        vecs[2] = '{8'h00, 1'b1, 2, 8'h00};
        vecs[3] = '{8'h5A, 1'b0, 2, 8'h00};
        vecs[4] = '{8'hC6, 1'b1, 1, 8'hC6};
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].gap, -1);
            check("tbl_rx_data", bus.rx_data, vecs[v].exp_data);
            check("tbl_busy", bus.busy, 1'b0);
            check("tbl_vld_count", vld_seen, exp_vld);
            check("tbl_ferr_count", ferr_seen, exp_ferr);
        end

        // False start: 4 ticks low then high
        drive_bit(1'b0, 2);
        check("fs_busy_during", bus.busy, 1'b1);
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 16);
        check("fs_busy_after", bus.busy, 1'b0);
        check("fs_vld_count", vld_seen, exp_vld);
        check("fs_ferr_count", ferr_seen, exp_ferr);

        // Break: 0xFF with low stop, line low 30 bit times, then 0x3C
        send_frame(8'hFF, 1'b0, 0, -1);
        drive_bit(1'b0, 30 * 16);
        check("brk_rx_data_held", bus.rx_data, 8'hC6);
        check("brk_busy", bus.busy, 1'b1);
        check("brk_ferr_count", ferr_seen, exp_ferr);
        check("brk_vld_count", vld_seen, exp_vld);
        drive_bit(1'b1, 32);
        check("brk_busy_released", bus.busy, 1'b0);
        send_frame(8'h3C, 1'b1, 2, -1);
        check("brk_next_rx_data", bus.rx_data, 8'h3C);

        // Reset during data bit 4 of 0xF5 (upper bits high so the rest looks idle)
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 5);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_rx_data", bus.rx_data, 8'h00);
        check("mid_rst_rx_valid", bus.rx_valid, 1'b0);
        check("mid_rst_frame_err", bus.frame_err, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        reset = 1'b0;
        drive_bit(1'b1, 11 + 48 + 16 + 32);
        check("mid_rst_vld_count", vld_seen, exp_vld);
        check("mid_rst_ferr_count", ferr_seen, exp_ferr);
        send_frame(8'h81, 1'b1, 2, -1);
        check("post_rst_rx_data", bus.rx_data, 8'h81);

        // Tick stalled for 200 clk in the middle of data bit 4
        send_frame(8'h96, 1'b1, 2, 4);
        check("pause_rx_data", bus.rx_data, 8'h96);

        // Final scoreboard reconciliation
        check("end_queue_empty", exp_q.size(), 0);
        check("end_vld_count", vld_seen, exp_vld);
        check("end_ferr_count", ferr_seen, exp_ferr);
        check("end_valid_with_ferr", both_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
